// File: rtl/ring_inject_arb_if.sv
// ---------------------------------------------------------------------------
// ring_inject_arb_if
// Bundles the local-request handshake, the incoming Q502H ring slot and the
// registered Q503H ring output of ring_inject_arb.
//   master : the environment (core request source, upstream ring, consumer)
//   slave  : ring_inject_arb itself
// Signals:
//   CoreReq{Valid,Opcode,Address,Data}Q502H  local request into the FIFO
//   CoreReqReadyQ502H                        FIFO can accept
//   Slot{Valid,Opcode,Address,Data}Q502H     incoming ring slot
//   Rsp{Valid,Opcode,Address,Data}Q503H      registered ring output
//   RingThrottleQ503H                        ask upstream to leave a slot empty
//   InjectCntQnnnH                           wrapping count of injections
// ---------------------------------------------------------------------------
interface ring_inject_arb_if #(
  parameter int OP_W = 4,
  parameter int XLEN = 32
);
  logic            CoreReqValidQ502H;
  logic            CoreReqReadyQ502H;
  logic [OP_W-1:0] CoreReqOpcodeQ502H;
  logic [XLEN-1:0] CoreReqAddressQ502H;
  logic [XLEN-1:0] CoreReqDataQ502H;
  logic            SlotValidQ502H;
  logic [OP_W-1:0] SlotOpcodeQ502H;
  logic [XLEN-1:0] SlotAddressQ502H;
  logic [XLEN-1:0] SlotDataQ502H;
  logic            RspValidQ503H;
  logic [OP_W-1:0] RspOpcodeQ503H;
  logic [XLEN-1:0] RspAddressQ503H;
  logic [XLEN-1:0] RspDataQ503H;
  logic            RingThrottleQ503H;
  logic [15:0]     InjectCntQnnnH;

  modport master (
    output CoreReqValidQ502H, CoreReqOpcodeQ502H, CoreReqAddressQ502H, CoreReqDataQ502H,
    output SlotValidQ502H, SlotOpcodeQ502H, SlotAddressQ502H, SlotDataQ502H,
    input  CoreReqReadyQ502H,
    input  RspValidQ503H, RspOpcodeQ503H, RspAddressQ503H, RspDataQ503H,
    input  RingThrottleQ503H, InjectCntQnnnH
  );

  modport slave (
    input  CoreReqValidQ502H, CoreReqOpcodeQ502H, CoreReqAddressQ502H, CoreReqDataQ502H,
    input  SlotValidQ502H, SlotOpcodeQ502H, SlotAddressQ502H, SlotDataQ502H,
    output CoreReqReadyQ502H,
    output RspValidQ503H, RspOpcodeQ503H, RspAddressQ503H, RspDataQ503H,
    output RingThrottleQ503H, InjectCntQnnnH
  );
endinterface

// File: rtl/ring_inject_arb.sv
// ---------------------------------------------------------------------------
// ring_inject_arb
// Shares the tile's outgoing ring slot between pass-through ring traffic and
// locally generated requests. Local requests wait in a DEPTH-entry FIFO and
// are injected only into empty slots; ring traffic is never stalled or
// modified. A starvation monitor raises RingThrottleQ503H when a queued
// request has been blocked for STARVE_MAX consecutive cycles.
// Ports:
//   QClk      clock
//   RstQnnnH  synchronous, active-high reset
//   ring_if   ring_inject_arb_if.slave (request handshake, slot in, Q503H out)
// ---------------------------------------------------------------------------
module ring_inject_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 16,
  parameter int CNT_W      = 5,
  parameter int OP_W       = 4,
  parameter int XLEN       = 32
) (
  input logic              QClk,
  input logic              RstQnnnH,
  ring_inject_arb_if.slave ring_if
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PEND    = 2'd1;
  localparam logic [1:0] ST_STARVED = 2'd2;

  // FIFO storage and bookkeeping
  logic [OP_W-1:0] mem_op_q   [DEPTH];
  logic [XLEN-1:0] mem_addr_q [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  // Starvation monitor
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  // Registered ring output
  logic            rsp_valid_q, rsp_valid_d;
  logic [OP_W-1:0] rsp_op_q, rsp_op_d;
  logic [XLEN-1:0] rsp_addr_q, rsp_addr_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            throttle_q, throttle_d;
  logic [15:0]     inject_cnt_q, inject_cnt_d;

  logic full_s;
  logic empty_s;
  logic ready_s;
  logic push_s;
  logic inject_s;

  // Ready comes from the registered count only: a full FIFO refuses a push
  // even in a cycle where it pops.
  assign full_s   = (count_q == (AW+1)'(DEPTH));
  assign empty_s  = (count_q == '0);
  assign ready_s  = !full_s && !RstQnnnH;
  assign push_s   = ring_if.CoreReqValidQ502H && ready_s;
  assign inject_s = !ring_if.SlotValidQ502H && !empty_s;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (inject_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, inject_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Slot arbitration: FIFO head fills an empty slot, else the slot passes through
  always_comb begin
    rsp_valid_d  = ring_if.SlotValidQ502H;
    rsp_op_d     = ring_if.SlotOpcodeQ502H;
    rsp_addr_d   = ring_if.SlotAddressQ502H;
    rsp_data_d   = ring_if.SlotDataQ502H;
    inject_cnt_d = inject_cnt_q;
    if (inject_s) begin
      rsp_valid_d  = 1'b1;
      rsp_op_d     = mem_op_q[rd_ptr_q];
      rsp_addr_d   = mem_addr_q[rd_ptr_q];
      rsp_data_d   = mem_data_q[rd_ptr_q];
      inject_cnt_d = inject_cnt_q + 16'd1;
    end else begin
      inject_cnt_d = inject_cnt_q;
    end
  end

  // Starvation FSM: counts blocked cycles while a request waits
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        // FIFO is empty here, so a blocked slot cannot starve anyone yet.
        if (push_s) begin
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (inject_s) begin
          starve_d = '0;
          state_d  = (count_d == '0) ? ST_IDLE : ST_PEND;
        end else begin
          // Non-empty and not injecting means the slot was occupied.
          starve_d = starve_q + CNT_W'(1);
          state_d  = (starve_d >= CNT_W'(STARVE_MAX)) ? ST_STARVED : ST_PEND;
        end
      end
      ST_STARVED: begin
        if (inject_s) begin
          starve_d = '0;
          state_d  = (count_d == '0) ? ST_IDLE : ST_PEND;
        end else begin
          starve_d = starve_q;
          state_d  = ST_STARVED;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        starve_d = '0;
      end
    endcase
    throttle_d = (state_d == ST_STARVED);
  end

  // FIFO storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge QClk) begin
    if (push_s) begin
      mem_op_q[wr_ptr_q]   <= ring_if.CoreReqOpcodeQ502H;
      mem_addr_q[wr_ptr_q] <= ring_if.CoreReqAddressQ502H;
      mem_data_q[wr_ptr_q] <= ring_if.CoreReqDataQ502H;
    end
  end

  // State, counters and Q503H output registers
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= '0;
      rsp_addr_q   <= '0;
      rsp_data_q   <= '0;
      throttle_q   <= 1'b0;
      inject_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      starve_q     <= starve_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_data_q   <= rsp_data_d;
      throttle_q   <= throttle_d;
      inject_cnt_q <= inject_cnt_d;
    end
  end

  assign ring_if.CoreReqReadyQ502H = ready_s;
  assign ring_if.RspValidQ503H     = rsp_valid_q;
  assign ring_if.RspOpcodeQ503H    = rsp_op_q;
  assign ring_if.RspAddressQ503H   = rsp_addr_q;
  assign ring_if.RspDataQ503H      = rsp_data_q;
  assign ring_if.RingThrottleQ503H = throttle_q;
  assign ring_if.InjectCntQnnnH    = inject_cnt_q;

endmodule

// File: doc/ring_inject_arb.md
Name: ring_inject_arb

Overview:
- Shares the tile's outgoing ring slot between pass-through ring traffic and locally generated requests to remote tiles.
- Sits after the io_ctrl Q502H response/pass-through mux and drives the Q503H ring output registers.
- Local requests are buffered in a small FIFO. They are injected only into empty ring slots; ring traffic always has priority and is never stalled.
- A starvation monitor asks the upstream ring source to throttle when local requests wait too long.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- STARVE_MAX, 16, consecutive blocked cycles before throttle asserts
- CNT_W, 5, width of starvation counter (must hold STARVE_MAX)

Ports:
- QClk  in  1  clock
- RstQnnnH  in  1  reset; synchronous, active-high
- CoreReqValidQ502H  in  1  local request valid
- CoreReqReadyQ502H  out  1  FIFO can accept
- CoreReqOpcodeQ502H  in  t_req_op  local request opcode
- CoreReqAddressQ502H  in  t_xlen  local request address
- CoreReqDataQ502H  in  t_xlen  local request data
- SlotValidQ502H  in  1  incoming ring slot occupied
- SlotOpcodeQ502H  in  t_req_op  incoming slot opcode
- SlotAddressQ502H  in  t_xlen  incoming slot address
- SlotDataQ502H  in  t_xlen  incoming slot data
- RspValidQ503H  out  1  ring output valid (registered)
- RspOpcodeQ503H  out  t_req_op  ring output opcode (registered)
- RspAddressQ503H  out  t_xlen  ring output address (registered)
- RspDataQ503H  out  t_xlen  ring output data (registered)
- RingThrottleQ503H  out  1  request upstream to leave a slot empty (registered)
- InjectCntQnnnH  out  16  count of injected requests, wraps

Behaviour:
- Clock and reset: one clock, QClk. Reset RstQnnnH is synchronous and active-high.
- Reset values:
  - All Q503H outputs 0; RingThrottleQ503H 0; InjectCntQnnnH 0.
  - FIFO empty, starvation counter 0, FSM in IDLE.
  - CoreReqReadyQ502H is forced 0 while RstQnnnH=1.
- Reset mid-operation: FIFO contents are discarded with no output. A slot presented in the reset cycle is not forwarded.
- FIFO:
  - Push on CoreReqValidQ502H && CoreReqReadyQ502H.
  - CoreReqReadyQ502H = !full, from the registered occupancy count. No pop-to-push bypass: a full FIFO rejects even when a pop occurs in the same cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
- Arbitration (combinational at Q502H, result registered into Q503H):
  - Inject = !SlotValidQ502H && !empty.
  - When Inject=1: Rsp* <= FIFO head with Valid=1; pop the head; InjectCnt +1 (wraps 0xFFFF->0).
  - Otherwise Rsp* <= Slot* fields unchanged, including Valid=0 with whatever fields are present.
  - An occupied slot is never modified or dropped.
- Latency:
  - A request accepted in cycle N is at the FIFO head in N+1.
  - With an empty slot in N+1, it appears on RspValidQ503H in N+2.
  - There is no same-cycle bypass from CoreReq to the ring.
- FIFO ordering: strictly in order.
- FSM (state registered):
  - IDLE: FIFO empty. Go to PEND on push.
  - PEND: FIFO non-empty, counter < STARVE_MAX.
    - Blocked cycle (SlotValid=1): counter +1.
    - Inject: counter clears to 0. Go to IDLE if the FIFO becomes empty and there is no push, else stay in PEND.
    - Counter reaches STARVE_MAX: go to STARVED.
  - STARVED: counter saturates. On inject, counter clears to 0 and the next state is IDLE or PEND per the same rule as PEND.
- RingThrottleQ503H: registered, = (next state == STARVED). It deasserts in the cycle after the injecting cycle.
- Counter: a simultaneous push and block while the FIFO is non-empty still increments it. Push alone never increments it.

Test Plan:
- Reset, then a single push (opcode RD, address 0x0040_0010, data 0) with all slots empty -> Ready=1 after reset; RspValidQ503H=1 with the pushed fields exactly 2 cycles after acceptance; InjectCnt=1.
- Continuous occupied slots, address 0x1230_0000 passing through, while 4 pushes are made -> all slots forwarded unchanged at +1 cycle latency; Ready=0 after the 4th push; 5th push held until a pop.
- FIFO full plus a 1-cycle empty slot while a push is valid -> head injected; Ready stays 0 in the pop cycle and returns to 1 the next cycle; order preserved.
- One queued request with slots occupied for 16 cycles -> RingThrottleQ503H rises after the 16th blocked cycle. After an empty slot: request injected, throttle falls the next cycle, counter 0, FSM IDLE.
- Inject 65537 requests -> InjectCntQnnnH wraps to 1.
- Assert reset with 3 queued entries and throttle high -> next cycle all outputs 0, FIFO empty, no stale injection afterward.
